// File: rtl/fp_normalizer_if.sv
// fp_normalizer_if: operand/result handshake bundle for the iterative left-normalizer.
interface fp_normalizer_if #(
    parameter int MANT_W = 28,
    parameter int EXP_W  = 8,
    parameter int SH_W   = $clog2(MANT_W + 1)
);
    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic [EXP_W-1:0]  in_exp;
    logic [MANT_W-1:0] in_mant;
    logic              out_valid;
    logic              out_ready;
    logic              out_sign;
    logic [EXP_W-1:0]  out_exp;
    logic [MANT_W-1:0] out_mant;
    logic [SH_W-1:0]   out_shift;
    logic              out_zero;
    modport master (
        output in_valid, in_sign, in_exp, in_mant, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_mant, out_shift, out_zero
    );
    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_mant, out_shift, out_zero
    );
endinterface

// File: rtl/fp_normalizer.sv
// fp_normalizer: shifts a mantissa left one nibble per cycle until normalized, bounded by exponent headroom.
module fp_normalizer #(
    parameter int MANT_W = 28,
    parameter int EXP_W  = 8,
    parameter int SH_W   = $clog2(MANT_W + 1)
) (
    input logic clk,
    input logic rst,
    fp_normalizer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state;
    logic [3:0] top;
    logic [2:0] k, amt;
    logic [EXP_W-1:0] em1, nexp;
    logic [MANT_W-1:0] nmant;
    logic fin;
    assign bus.in_ready = (state == IDLE);
    // The output registers double as the working mantissa/exponent while in SHIFT.
    always_comb begin
        top   = bus.out_mant[MANT_W-1 -: 4];
        k     = top[3] ? 3'd0 : top[2] ? 3'd1 : top[1] ? 3'd2 : top[0] ? 3'd3 : 3'd4;
        em1   = bus.out_exp - EXP_W'(1);
        amt   = (EXP_W'(k) > em1) ? em1[2:0] : k;
        nmant = bus.out_mant << amt;
        nexp  = bus.out_exp - EXP_W'(amt);
        fin   = (k != 3'd4) || (amt != k);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.out_sign  <= 1'b0;
            bus.out_exp   <= '0;
            bus.out_mant  <= '0;
            bus.out_shift <= '0;
            bus.out_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    bus.out_sign  <= bus.in_sign;
                    bus.out_shift <= '0;
                    bus.out_zero  <= (bus.in_mant == '0);
                    bus.out_exp   <= (bus.in_mant == '0) ? '0 : bus.in_exp;
                    bus.out_mant  <= bus.in_mant;
                    if (bus.in_mant == '0 || bus.in_exp == '0) begin
                        state         <= DONE;
                        bus.out_valid <= 1'b1;
                    end else begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    bus.out_mant  <= nmant;
                    bus.out_shift <= bus.out_shift + SH_W'(amt);
                    // Exponent stuck at 1 with an unnormalized mantissa is encoded as denormal.
                    bus.out_exp   <= (fin && nexp == EXP_W'(1) && !nmant[MANT_W-1]) ? '0 : nexp;
                    if (fin) begin
                        state         <= DONE;
                        bus.out_valid <= 1'b1;
                    end
                end
                DONE: if (bus.out_ready) begin
                    state         <= IDLE;
                    bus.out_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_normalizer.sv
// tb_fp_normalizer: directed vector table plus back-pressure and mid-operation reset sequences.
module tb_fp_normalizer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    fp_normalizer_if #(.MANT_W(28), .EXP_W(8), .SH_W(5)) bus ();
    fp_normalizer #(.MANT_W(28), .EXP_W(8), .SH_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        logic        sign;
        logic [7:0]  exp;
        logic [27:0] mant;
        logic [7:0]  e_exp;
        logic [27:0] e_mant;
        logic [4:0]  e_shift;
        logic        e_zero;
        int          e_lat;
    } vec_t;
    vec_t vecs[9];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask
    task automatic send(input logic s, input logic [7:0] e, input logic [27:0] m);
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_sign  = s;
        bus.in_exp   = e;
        bus.in_mant  = m;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sign  = ~s;
        bus.in_exp   = 8'hff;
        bus.in_mant  = 28'hfffffff;
    endtask
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask
    task automatic handshake();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("hs_valid_drop", {31'd0, bus.out_valid}, 32'd0);
        chk("hs_ready_rise", {31'd0, bus.in_ready}, 32'd1);
    endtask
    task automatic check_out(input vec_t v, input int lat);
        chk("latency", lat, v.e_lat);
        chk("out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("out_sign", {31'd0, bus.out_sign}, {31'd0, v.sign});
        chk("out_exp", {24'd0, bus.out_exp}, {24'd0, v.e_exp});
        chk("out_mant", {4'd0, bus.out_mant}, {4'd0, v.e_mant});
        chk("out_shift", {27'd0, bus.out_shift}, {27'd0, v.e_shift});
        chk("out_zero", {31'd0, bus.out_zero}, {31'd0, v.e_zero});
    endtask
    initial begin
        int lat;
        int bad;
        vecs[0] = '{1'b0, 8'd100, 28'h8000000, 8'd100, 28'h8000000, 5'd0,  1'b0, 2};
        vecs[1] = '{1'b1, 8'd130, 28'h0800000, 8'd126, 28'h8000000, 5'd4,  1'b0, 3};
        vecs[2] = '{1'b0, 8'd10,  28'h0000100, 8'd0,   28'h0020000, 5'd9,  1'b0, 4};
        vecs[3] = '{1'b1, 8'd77,  28'h0000000, 8'd0,   28'h0000000, 5'd0,  1'b1, 1};
        vecs[4] = '{1'b0, 8'd0,   28'h0001234, 8'd0,   28'h0001234, 5'd0,  1'b0, 1};
        vecs[5] = '{1'b0, 8'd200, 28'h0000001, 8'd173, 28'h8000000, 5'd27, 1'b0, 8};
        vecs[6] = '{1'b1, 8'd1,   28'h0400000, 8'd0,   28'h0400000, 5'd0,  1'b0, 2};
        vecs[7] = '{1'b0, 8'd3,   28'h1000000, 8'd0,   28'h4000000, 5'd2,  1'b0, 2};
        vecs[8] = '{1'b0, 8'd50,  28'h0123456, 8'd43,  28'h91a2b00, 5'd7,  1'b0, 3};
        bus.in_valid = 1'b0;
        bus.in_sign = 1'b0;
        bus.in_exp = '0;
        bus.in_mant = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_outputs", {bus.out_sign, bus.out_zero, bus.out_shift, bus.out_exp, 17'd0},
            32'd0);
        chk("rst_out_mant", {4'd0, bus.out_mant}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            send(vecs[i].sign, vecs[i].exp, vecs[i].mant);
            wait_valid(lat);
            check_out(vecs[i], lat);
            handshake();
        end
        // Back-pressure: result must hold while out_ready stays low.
        send(vecs[1].sign, vecs[1].exp, vecs[1].mant);
        wait_valid(lat);
        check_out(vecs[1], lat);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            if (!bus.out_valid || bus.in_ready || bus.out_mant !== 28'h8000000 ||
                bus.out_exp !== 8'd126 || bus.out_shift !== 5'd4 || !bus.out_sign) bad++;
        end
        bus.in_valid = 1'b0;
        chk("backpressure_hold", bad, 0);
        check_out(vecs[1], lat);
        handshake();
        // Reset while shifting the max-shift operand.
        send(vecs[5].sign, vecs[5].exp, vecs[5].mant);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("mid_shift_no_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_shift_busy", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("async_rst_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("async_rst_shift", {27'd0, bus.out_shift}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid || !bus.in_ready) bad++;
        end
        chk("no_stale_result", bad, 0);
        send(vecs[8].sign, vecs[8].exp, vecs[8].mant);
        wait_valid(lat);
        check_out(vecs[8], lat);
        handshake();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
